// File: rtl/serial_arith_pkg.sv
// Shared types and limits for the bit-serial arithmetic controllers.
package serial_arith_pkg;

  localparam int SA_WIDTH_MIN = 1;
  localparam int SA_WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } sa_state_e;

endpackage

// File: rtl/full_adder.sv
// One-bit combinational full adder cell, time-shared by the serial controller.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder reused over WIDTH clocks, LSB first,
// operands in and result out over independent valid/ready handshakes.
//
// state | meaning
// IDLE  | waiting for operands, start_ready high
// RUN   | one bit per clock through the shared full adder
// DONE  | result held on sum/cout until done_ready
module serial_adder_ctrl
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  if (WIDTH < SA_WIDTH_MIN || WIDTH > SA_WIDTH_MAX) begin : g_bad_width
    $error("serial_adder_ctrl: WIDTH out of range");
  end

  sa_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             fa_s, fa_cout;
  logic             last_bit;

  full_adder u_fa (
    .A    (opa_q[0]),
    .B    (opb_q[0]),
    .Cin  (carry_q),
    .S    (fa_s),
    .Cout (fa_cout)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    start_ready = 1'b0;
    done_valid  = 1'b0;
    busy        = 1'b0;
    case (state_q)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          opa_d   = a;
          opb_d   = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        busy    = 1'b1;
        carry_d = fa_cout;
        // Sum bits enter at the MSB so the LSB lands in bit 0 after WIDTH shifts.
        acc_d   = (acc_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_bit) begin
          sum_d   = acc_d;
          cout_d  = fa_cout;
          state_d = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done_valid = 1'b1;
        if (done_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks of serial_adder_ctrl at WIDTH 8, 13 and 1.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] a_t, b_t;
  logic        cin_t, dr_t;
  logic [2:0]  sv_t;

  logic        sr8, dv8, co8, bz8;
  logic [7:0]  s8;
  logic        sr13, dv13, co13, bz13;
  logic [12:0] s13;
  logic        sr1, dv1, co1, bz1;
  logic [0:0]  s1;

  int n_run  = 0;
  int n_fail = 0;

  serial_adder_ctrl #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv_t[0]), .start_ready(sr8),
    .a(a_t[7:0]), .b(b_t[7:0]), .cin(cin_t), .done_valid(dv8),
    .done_ready(dr_t), .sum(s8), .cout(co8), .busy(bz8));

  serial_adder_ctrl #(.WIDTH(13)) u_w13 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv_t[1]), .start_ready(sr13),
    .a(a_t[12:0]), .b(b_t[12:0]), .cin(cin_t), .done_valid(dv13),
    .done_ready(dr_t), .sum(s13), .cout(co13), .busy(bz13));

  serial_adder_ctrl #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv_t[2]), .start_ready(sr1),
    .a(a_t[0:0]), .b(b_t[0:0]), .cin(cin_t), .done_valid(dv1),
    .done_ready(dr_t), .sum(s1), .cout(co1), .busy(bz1));

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  vec_t vecs[10];

  function automatic int wid(input int d);
    case (d)
      0:       return 8;
      1:       return 13;
      default: return 1;
    endcase
  endfunction

  function automatic logic [31:0] get_sum(input int d);
    case (d)
      0:       return {24'b0, s8};
      1:       return {19'b0, s13};
      default: return {31'b0, s1};
    endcase
  endfunction

  function automatic logic get_dv(input int d);
    case (d)
      0:       return dv8;
      1:       return dv13;
      default: return dv1;
    endcase
  endfunction

  function automatic logic get_co(input int d);
    case (d)
      0:       return co8;
      1:       return co13;
      default: return co1;
    endcase
  endfunction

  function automatic logic get_bz(input int d);
    case (d)
      0:       return bz8;
      1:       return bz13;
      default: return bz1;
    endcase
  endfunction

  function automatic logic get_sr(input int d);
    case (d)
      0:       return sr8;
      1:       return sr13;
      default: return sr1;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_done(input int d, inout int lat);
    while (get_dv(d) !== 1'b1 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input int d, input logic [31:0] av, input logic [31:0] bv,
                        input logic cv, input logic [31:0] es, input logic ec,
                        input string tag);
    int lat;
    @(negedge clk);
    a_t = av; b_t = bv; cin_t = cv; dr_t = 1'b0;
    sv_t[d] = 1'b1;
    @(posedge clk); #1;
    sv_t[d] = 1'b0;
    chk({tag, ".busy_run"}, 32'(get_bz(d)), 32'd1);
    lat = 0;
    wait_done(d, lat);
    chk({tag, ".latency"}, lat, wid(d));
    chk({tag, ".sum"}, get_sum(d), es);
    chk({tag, ".cout"}, 32'(get_co(d)), 32'(ec));
    dr_t = 1'b1;
    @(posedge clk); #1;
    dr_t = 1'b0;
    chk({tag, ".dv_after_hs"}, 32'(get_dv(d)), 32'd0);
    chk({tag, ".ready_after_hs"}, 32'(get_sr(d)), 32'd1);
    chk({tag, ".sum_kept"}, get_sum(d), es);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] av, bv;
    logic        cv;
    logic [32:0] tot;

    vecs[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    vecs[7] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs[8] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
    vecs[9] = '{8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1};

    rst_n = 1'b0; a_t = '0; b_t = '0; cin_t = 1'b0; dr_t = 1'b0; sv_t = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.start_ready", 32'(sr8), 32'd1);
    chk("rst.done_valid", 32'(dv8), 32'd0);
    chk("rst.busy", 32'(bz8), 32'd0);
    chk("rst.sum", 32'(s8), 32'd0);
    chk("rst.cout", 32'(co8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++)
      run_op(0, 32'(vecs[i].a), 32'(vecs[i].b), vecs[i].cin,
             32'(vecs[i].sum), vecs[i].cout, $sformatf("vec%0d", i));

    // Backpressure, with operand churn and stray start_valid during RUN and DONE
    @(negedge clk);
    a_t = 32'h5A; b_t = 32'h33; cin_t = 1'b0; sv_t[0] = 1'b1;
    @(posedge clk); #1;
    sv_t[0] = 1'b0;
    lat = 0;
    repeat (3) begin @(posedge clk); #1; lat++; end
    a_t = 32'hFF; b_t = 32'hFF; cin_t = 1'b1; sv_t[0] = 1'b1;
    wait_done(0, lat);
    chk("bp.latency", lat, 8);
    for (int k = 0; k < 6; k++) begin
      chk("bp.dv", 32'(dv8), 32'd1);
      chk("bp.sum", 32'(s8), 32'h8D);
      chk("bp.cout", 32'(co8), 32'd0);
      chk("bp.start_ready", 32'(sr8), 32'd0);
      if (k < 5) begin @(posedge clk); #1; end
    end
    sv_t[0] = 1'b0;
    dr_t = 1'b1;
    @(posedge clk); #1;
    dr_t = 1'b0;
    chk("bp.dv_after_hs", 32'(dv8), 32'd0);
    chk("bp.sum_kept", 32'(s8), 32'h8D);
    @(posedge clk); #1;
    chk("bp.no_stray_accept", 32'(bz8), 32'd0);

    // Asynchronous reset at the 4th RUN edge
    @(negedge clk);
    a_t = 32'hFF; b_t = 32'h01; cin_t = 1'b0; sv_t[0] = 1'b1;
    @(posedge clk); #1;
    sv_t[0] = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("mid_rst.start_ready", 32'(sr8), 32'd1);
    chk("mid_rst.done_valid", 32'(dv8), 32'd0);
    chk("mid_rst.busy", 32'(bz8), 32'd0);
    chk("mid_rst.sum", 32'(s8), 32'd0);
    chk("mid_rst.cout", 32'(co8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 32'h10, 32'h20, 1'b0, 32'h30, 1'b0, "post_rst");

    // Back-to-back: start_valid held through the done handshake
    @(negedge clk);
    a_t = 32'h03; b_t = 32'h04; cin_t = 1'b0; sv_t[0] = 1'b1; dr_t = 1'b1;
    @(posedge clk); #1;
    a_t = 32'h01; b_t = 32'h01;
    lat = 0;
    wait_done(0, lat);
    chk("b2b.first_latency", lat, 8);
    chk("b2b.first_sum", 32'(s8), 32'h07);
    @(posedge clk); #1;
    chk("b2b.hs_dv", 32'(dv8), 32'd0);
    chk("b2b.hs_ready", 32'(sr8), 32'd1);
    @(posedge clk); #1;
    sv_t[0] = 1'b0;
    chk("b2b.second_accept", 32'(bz8), 32'd1);
    chk("b2b.second_ready", 32'(sr8), 32'd0);
    lat = 0;
    wait_done(0, lat);
    chk("b2b.second_latency", lat, 8);
    chk("b2b.second_sum", 32'(s8), 32'h02);
    chk("b2b.second_cout", 32'(co8), 32'd0);
    @(posedge clk); #1;
    dr_t = 1'b0;
    chk("b2b.second_hs", 32'(dv8), 32'd0);

    // WIDTH=1 instance
    run_op(2, 32'd1, 32'd1, 1'b1, 32'd1, 1'b1, "w1.111");
    run_op(2, 32'd0, 32'd0, 1'b1, 32'd1, 1'b0, "w1.001");
    run_op(2, 32'd1, 32'd0, 1'b0, 32'd1, 1'b0, "w1.100");
    run_op(2, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, "w1.000");

    for (int i = 0; i < 1000; i++) begin
      av  = $urandom & 32'hFF;
      bv  = $urandom & 32'hFF;
      cv  = 1'($urandom_range(0, 1));
      tot = 33'(av) + 33'(bv) + 33'(cv);
      run_op(0, av, bv, cv, {24'b0, tot[7:0]}, tot[8], "rnd8");
    end

    for (int i = 0; i < 1000; i++) begin
      av  = $urandom & 32'h1FFF;
      bv  = $urandom & 32'h1FFF;
      cv  = 1'($urandom_range(0, 1));
      tot = 33'(av) + 33'(bv) + 33'(cv);
      run_op(1, av, bv, cv, {19'b0, tot[12:0]}, tot[13], "rnd13");
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial addition controller. It time-shares the team's single one-bit full_adder cell across a WIDTH-bit add, one bit per clock, LSB first. The carry is held in a flip-flop between bits. It accepts operands over a valid/ready handshake and returns sum/carry over a second valid/ready handshake. Its purpose is low-area arithmetic for slow control paths.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 1..32.
CNT_W, $clog2(WIDTH+1), bit-counter width (derived; not to be overridden).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start_valid  input  1  operands a/b/cin presented
start_ready  output  1  controller can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  initial carry-in
done_valid  output  1  result available on sum/cout
done_ready  input  1  consumer accepts result
sum  output  WIDTH  registered sum
cout  output  1  registered final carry-out
busy  output  1  high in RUN and DONE

Behaviour:
- Reset (rst_n low, async): state=IDLE; start_ready=1; done_valid=0; busy=0; sum=0; cout=0; counter=0; carry flop=0; shift registers=0.
- FSM states:
  - IDLE: start_ready=1, busy=0.
  - RUN: start_ready=0, busy=1.
  - DONE: start_ready=0, done_valid=1, busy=1.
- Accept edge (IDLE, start_valid & start_ready):
  - latch a and b into shift registers; carry flop <= cin; counter <= 0; state -> RUN.
  - a/b/cin are ignored on all other edges.
- RUN, each edge:
  - full_adder inputs: A = opA_sr[0], B = opB_sr[0], Cin = carry flop.
  - carry flop <= Cout.
  - sum shift register shifts right, with S entering at MSB.
  - opA_sr and opB_sr shift right.
  - counter++.
  - When counter == WIDTH-1 on this edge: state -> DONE, sum <= final shifted value, cout <= Cout.
- Latency: done_valid rises exactly WIDTH clock edges after the accept edge. WIDTH=1 gives DONE one edge after accept.
- DONE:
  - sum/cout held stable while done_valid=1 and done_ready=0 (backpressure of any length).
  - On the edge with done_ready=1: done_valid -> 0, state -> IDLE.
  - sum/cout keep their last value until the next DONE (not cleared).
- No back-to-back overlap: start_ready is low in DONE. A start_valid asserted simultaneously with the done handshake is accepted on the following edge (earliest).
- done_ready while not in DONE: ignored.
- start_valid while in RUN/DONE: ignored; no buffering.
- Arithmetic is modulo 2^WIDTH. cout is the true carry of a + b + cin.
- Reset mid-RUN or mid-DONE: immediate abort to reset values; the partial result is discarded.
- State encoding: 2-bit. The unused encoding returns to IDLE.

Decomposition:
- Shared package serial_arith_pkg: state enum (IDLE/RUN/DONE) and WIDTH limit constants.
- One sub-module instance: the existing full_adder cell (ports A, B, Cin, S, Cout), which is purely combinational.
- The controller owns all flops: FSM, counter, shift registers, carry.

Test Plan:
- WIDTH=8, a=0x5A, b=0x33, cin=0 -> after 8 edges done_valid=1, sum=0x8D, cout=0; busy high from accept through the done handshake.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1 (full ripple across all bits).
- Backpressure: hold done_ready=0 for 5 cycles after done_valid -> sum/cout/done_valid stable. Also change a/b and pulse start_valid during RUN and DONE -> no effect; result unchanged.
- Reset mid-op: assert rst_n=0 at the 4th RUN edge -> all outputs 0 immediately, state=IDLE. After release, a=0x10, b=0x20 -> sum=0x30, cout=0.
- Back-to-back: start_valid held high with done_ready=1 -> second operand pair accepted on the edge after the done handshake. Second result 0x01+0x01 = 0x02 appears 8 edges later.
- WIDTH=1 build: a=1, b=1, cin=1 -> sum=1, cout=1, one edge after accept. Random 1000-op compare against a + b + cin at WIDTH=8 and WIDTH=13.
